// File: rtl/maxnet_sequencer_pkg.sv
// Shared types and helpers for the MaxNet iteration sequencer.
// Holds the FSM state encoding, the neuron count and the IEEE-754 zero test.
package maxnet_sequencer_pkg;

    localparam int unsigned N_NEURON = 4;
    localparam int unsigned IDX_W    = 2;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StCheck,
        StDone
    } state_e;

    // Sign bit ignored so that -0.0 is treated as zero.
    function automatic logic fp_is_zero(logic [31:0] v);
        return (v[30:0] == 31'd0);
    endfunction

endpackage

// File: rtl/maxnet_sequencer_if.sv
// Bus between the sequencer and the shared 4-input neuron processing unit.
// master = sequencer side, slave = PU / weight-row mux side.
interface maxnet_sequencer_if #(
    parameter int unsigned DW = 32
);
    logic [DW-1:0] pu_a1;
    logic [DW-1:0] pu_a2;
    logic [DW-1:0] pu_a3;
    logic [DW-1:0] pu_a4;
    logic [1:0]    pu_w_sel;
    logic [DW-1:0] pu_out;

    modport master (
        output pu_a1,
        output pu_a2,
        output pu_a3,
        output pu_a4,
        output pu_w_sel,
        input  pu_out
    );

    modport slave (
        input  pu_a1,
        input  pu_a2,
        input  pu_a3,
        input  pu_a4,
        input  pu_w_sel,
        output pu_out
    );
endinterface

// File: rtl/mnseq_tag_pipe.sv
// DEPTH-deep {valid, idx} shift register tracking issues in flight through the PU.
// The tail lines up with the cycle in which the matching pu_out is valid.
module mnseq_tag_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       push_valid,
    input  logic [1:0] push_idx,
    output logic       tail_valid,
    output logic [1:0] tail_idx
);

    logic       vld_q [DEPTH];
    logic [1:0] idx_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                vld_q[i] <= 1'b0;
                idx_q[i] <= 2'd0;
            end
        end else begin
            vld_q[0] <= push_valid;
            idx_q[0] <= push_idx;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign tail_valid = vld_q[DEPTH-1];
    assign tail_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/maxnet_sequencer.sv
// MaxNet winner-take-all iteration controller: issues 4 neurons per iteration to a
// shared pipelined PU, double-buffers activations and stops on convergence or MAX_ITER.
module maxnet_sequencer
    import maxnet_sequencer_pkg::*;
#(
    parameter  int unsigned DW       = 32,
    parameter  int unsigned PU_LAT   = 2,
    parameter  int unsigned MAX_ITER = 15,
    localparam int unsigned ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DW-1:0]         x1,
    input  logic [DW-1:0]         x2,
    input  logic [DW-1:0]         x3,
    input  logic [DW-1:0]         x4,
    maxnet_sequencer_if.master    pu,
    output logic [DW-1:0]         y1,
    output logic [DW-1:0]         y2,
    output logic [DW-1:0]         y3,
    output logic [DW-1:0]         y4,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            winner,
    output logic                  none,
    output logic                  timeout,
    output logic [ITER_W-1:0]     iter_count
);

    state_e              state_q, state_d;
    logic [1:0]          issue_cnt_q, issue_cnt_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [1:0]          winner_q, winner_d;
    logic                none_q, none_d;
    logic                timeout_q, timeout_d;
    logic [DW-1:0]       a_cur_q [N_NEURON];
    logic [DW-1:0]       a_cur_d [N_NEURON];
    logic [DW-1:0]       a_nxt_q [N_NEURON];
    logic [DW-1:0]       a_nxt_d [N_NEURON];

    logic                start_accept;
    logic                push_valid;
    logic                tail_valid;
    logic [1:0]          tail_idx;
    logic [2:0]          nz_cnt;
    logic [1:0]          low_idx;
    logic                last_iter;

    assign push_valid = (state_q == StIssue);

    mnseq_tag_pipe #(
        .DEPTH (PU_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_accept),
        .push_valid (push_valid),
        .push_idx   (issue_cnt_q),
        .tail_valid (tail_valid),
        .tail_idx   (tail_idx)
    );

    // Convergence test runs on the freshly captured buffer, never on the loaded x.
    always_comb begin
        nz_cnt  = 3'd0;
        low_idx = 2'd0;
        for (int i = int'(N_NEURON) - 1; i >= 0; i--) begin
            if (!fp_is_zero(a_nxt_q[i])) begin
                nz_cnt  = nz_cnt + 3'd1;
                low_idx = 2'(i);
            end
        end
    end

    assign last_iter = ((32'(iter_q) + 32'd1) == MAX_ITER);

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        iter_d       = iter_q;
        winner_d     = winner_q;
        none_d       = none_q;
        timeout_d    = timeout_q;
        a_cur_d      = a_cur_q;
        a_nxt_d      = a_nxt_q;
        start_accept = 1'b0;

        if (tail_valid) begin
            a_nxt_d[tail_idx] = pu.pu_out;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    start_accept = 1'b1;
                    a_cur_d[0]   = x1;
                    a_cur_d[1]   = x2;
                    a_cur_d[2]   = x3;
                    a_cur_d[3]   = x4;
                    iter_d       = '0;
                    winner_d     = 2'd0;
                    none_d       = 1'b0;
                    timeout_d    = 1'b0;
                    issue_cnt_d  = 2'd0;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                issue_cnt_d = issue_cnt_q + 2'd1;
                if (issue_cnt_q == 2'(N_NEURON - 1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (tail_valid && (tail_idx == 2'(N_NEURON - 1))) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                a_cur_d = a_nxt_q;
                iter_d  = iter_q + ITER_W'(1);
                if (nz_cnt <= 3'd1) begin
                    state_d  = StDone;
                    none_d   = (nz_cnt == 3'd0);
                    winner_d = low_idx;
                end else if (last_iter) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                    winner_d  = low_idx;
                end else begin
                    issue_cnt_d = 2'd0;
                    state_d     = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            issue_cnt_q <= 2'd0;
            iter_q      <= '0;
            winner_q    <= 2'd0;
            none_q      <= 1'b0;
            timeout_q   <= 1'b0;
            for (int i = 0; i < int'(N_NEURON); i++) begin
                a_cur_q[i] <= '0;
                a_nxt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            iter_q      <= iter_d;
            winner_q    <= winner_d;
            none_q      <= none_d;
            timeout_q   <= timeout_d;
            a_cur_q     <= a_cur_d;
            a_nxt_q     <= a_nxt_d;
        end
    end

    assign pu.pu_a1    = a_cur_q[0];
    assign pu.pu_a2    = a_cur_q[1];
    assign pu.pu_a3    = a_cur_q[2];
    assign pu.pu_a4    = a_cur_q[3];
    assign pu.pu_w_sel = (state_q == StIssue) ? issue_cnt_q : 2'd0;

    assign y1 = a_cur_q[0];
    assign y2 = a_cur_q[1];
    assign y3 = a_cur_q[2];
    assign y4 = a_cur_q[3];

    assign busy       = (state_q == StIssue) || (state_q == StDrain) || (state_q == StCheck);
    assign done       = (state_q == StDone);
    assign winner     = winner_q;
    assign none       = none_q;
    assign timeout    = timeout_q;
    assign iter_count = iter_q;

endmodule
